fetch: RTL and testbench

Instruction-fetch stage of the demo1 single-cycle WISC datapath; it sits directly after the memory stage in the PC loop. It consumes the memory stage's resolved next PC (`outPC`), holds the architectural PC register, reads the instruction word from a read-only `memory2c` instance, and supplies `pc`/`pcPlus2` to decode/execute. It also detects HALT, freezes the machine, and triggers the instruction-memory dump.

---
 rtl/fetch.sv | 164 ++++++++++++++++
 tb/tb_fetch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: PC register, read-only instruction memory, HALT detection.
// Optional misaligned-PC trap is enabled with the FETCH_ALIGN_CHK_EN macro.

module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [15:0] g, p;
  logic [16:0] c;
  logic [3:0]  grp_g, grp_p;
  logic [4:0]  grp_c;

  // Group generate/propagate per nibble; carries look ahead across nibble boundaries.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    grp_c[0] = c_in;
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = grp_c[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[16] = grp_c[4];
    sum   = p ^ c[15:0];
    c_out = c[16];
  end
endmodule

module memory2c (
  output logic [15:0] data_out,
  input  logic [15:0] data_in,
  input  logic [15:0] addr,
  input  logic        enable,
  input  logic        wr,
  input  logic        createdump,
  input  logic        clk,
  input  logic        rst
);
  // Byte-addressed 64 KiB space stored as 32K half-words; addr[0] is ignored.
  logic [15:0] mem [0:32767];
  logic        dump_unused;

  assign dump_unused = ^{createdump, rst, addr[0]};
  assign data_out = (enable && !wr) ? mem[addr[15:1]] : 16'h0000;

  always_ff @(posedge clk) begin
    if (enable && wr) mem[addr[15:1]] <= data_in;
  end
endmodule

module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OP  = 5'b00000,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] nextPC,
  input  logic        pcWrEn,
  output logic [15:0] pc,
  output logic [15:0] pcPlus2,
  output logic [15:0] instr,
  output logic        halted,
  output logic [15:0] instrCount,
  output logic        err
);
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [15:0] mem_data;
  logic        createdump;
  logic        is_halt;
  logic        misalign;
  logic        cout_unused;

  memory2c u_imem (
    .data_out   (mem_data),
    .data_in    (16'h0000),
    .addr       (pc_q),
    .enable     (state_q == RUN),
    .wr         (1'b0),
    .createdump (createdump),
    .clk        (clk),
    .rst        (rst)
  );

  cla_16b u_pc_inc (
    .a     (pc_q),
    .b     (16'h0002),
    .c_in  (1'b0),
    .sum   (pcPlus2),
    .c_out (cout_unused)
  );

`ifdef FETCH_ALIGN_CHK_EN
  assign misalign = nextPC[0];
`else
  assign misalign = 1'b0;
`endif

  assign is_halt = (mem_data[15:11] == HALT_OP);

  // Halt beats stall and beats the alignment trap; both count as retiring only on a real fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    createdump = 1'b0;
    if (state_q == RUN) begin
      if (is_halt) begin
        state_d    = HALTED;
        createdump = 1'b1;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end else if (pcWrEn) begin
        if (misalign) begin
          state_d    = HALTED;
          err_d      = 1'b1;
          createdump = 1'b1;
        end else begin
          pc_d = nextPC;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pc         = pc_q;
  assign halted     = (state_q == HALTED);
  assign instr      = (state_q == HALTED) ? NOP_WORD : mem_data;
  assign instrCount = cnt_q;
  assign err        = err_q;
endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: reset, sequential fetch, stall, HALT, wrap, saturation, alignment.
// Expected values are hand-computed constants; FETCH_ALIGN_CHK_EN selects the alignment branch.

module tb_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] nextPC;
  logic        pcWrEn;
  logic [15:0] pc, pcPlus2, instr, instrCount;
  logic        halted, err;

  int checks = 0;
  int errors = 0;
  int dump_cnt = 0;
  int dump_base;

  fetch dut (
    .clk        (clk),
    .rst        (rst),
    .nextPC     (nextPC),
    .pcWrEn     (pcWrEn),
    .pc         (pc),
    .pcPlus2    (pcPlus2),
    .instr      (instr),
    .halted     (halted),
    .instrCount (instrCount),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.createdump) dump_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) dut.u_imem.mem[i] = 16'hC001;
    dut.u_imem.mem[16'h0020] = 16'h0000;
    rst = 1'b1;
    nextPC = 16'h0000;
    pcWrEn = 1'b0;
    #2;
    check("rst_pc", pc, 16'h0000);
    check("rst_instr", instr, 16'hC001);
    check("rst_pcplus2", pcPlus2, 16'h0002);
    check("rst_halted", halted, 1'b0);
    check("rst_count", instrCount, 16'h0000);
    check("rst_err", err, 1'b0);
    #1 rst = 1'b0;

    pcWrEn = 1'b1;
    nextPC = 16'h0002; step();
    check("seq1_pc", pc, 16'h0002);
    nextPC = 16'h0004; step();
    nextPC = 16'h0006; step();
    check("seq3_pc", pc, 16'h0006);
    check("seq3_count", instrCount, 16'd3);
    check("seq3_pcplus2", pcPlus2, 16'h0008);

    pcWrEn = 1'b0;
    nextPC = 16'h0040;
    step();
    check("stall1_pc", pc, 16'h0006);
    check("stall1_count", instrCount, 16'd3);
    step();
    check("stall2_pc", pc, 16'h0006);
    check("stall2_count", instrCount, 16'd3);
    pcWrEn = 1'b1;
    step();
    check("branch_pc", pc, 16'h0040);
    check("branch_count", instrCount, 16'd4);
    check("branch_instr", instr, 16'h0000);
    check("branch_halted", halted, 1'b0);

    pcWrEn = 1'b0;
    dump_base = dump_cnt;
    step();
    check("halt_halted", halted, 1'b1);
    check("halt_instr", instr, 16'h0800);
    check("halt_pc", pc, 16'h0040);
    check("halt_count", instrCount, 16'd5);
    check("halt_dump", dump_cnt - dump_base, 1);
    pcWrEn = 1'b1;
    nextPC = 16'h0100;
    step();
    step();
    check("frozen_pc", pc, 16'h0040);
    check("frozen_pcplus2", pcPlus2, 16'h0042);
    check("frozen_count", instrCount, 16'd5);
    check("frozen_halted", halted, 1'b1);
    check("frozen_dump", dump_cnt - dump_base, 1);

    rst = 1'b1;
    #1;
    check("rst2_halted", halted, 1'b0);
    check("rst2_pc", pc, 16'h0000);
    check("rst2_count", instrCount, 16'h0000);
    #1 rst = 1'b0;

    nextPC = 16'hFFFE;
    step();
    check("wrap_pc", pc, 16'hFFFE);
    check("wrap_pcplus2", pcPlus2, 16'h0000);
    check("wrap_instr", instr, 16'hC001);
    nextPC = 16'h0000;
    step();
    check("wrap_load_pc", pc, 16'h0000);
    check("wrap_count", instrCount, 16'd2);

    nextPC = 16'h0002;
    repeat (65540) step();
    check("sat_count", instrCount, 16'hFFFF);
    check("sat_halted", halted, 1'b0);

    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    nextPC = 16'h0013;
    pcWrEn = 1'b1;
    dump_base = dump_cnt;
    step();
`ifdef FETCH_ALIGN_CHK_EN
    check("align_pc", pc, 16'h0000);
    check("align_err", err, 1'b1);
    check("align_halted", halted, 1'b1);
    check("align_count", instrCount, 16'h0000);
    check("align_dump", dump_cnt - dump_base, 1);
`else
    check("odd_pc", pc, 16'h0013);
    check("odd_err", err, 1'b0);
    check("odd_halted", halted, 1'b0);
    check("odd_count", instrCount, 16'd1);
`endif
    #2 rst = 1'b1;
    #1;
    check("async_err", err, 1'b0);
    check("async_pc", pc, 16'h0000);
    check("async_halted", halted, 1'b0);
    rst = 1'b0;
    pcWrEn = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
